// File: rtl/jpeg_stream_arbiter.sv
// jpeg_stream_arbiter: buffers the Y, Cb and Cr Huffman word streams in per-channel FIFOs
// and serializes them in MCU order (Y block, Cb block, Cr block, repeat).
// Optional feature: define JSA_MCU_COUNT_EN to enable the completed-MCU counter;
// without it mcu_count is tied to zero.
module jpeg_stream_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ORC_W  = 5,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] y_data,
    input  logic              y_valid,
    input  logic [ORC_W-1:0]  y_orc,
    input  logic              y_eob,
    input  logic [DATA_W-1:0] cb_data,
    input  logic              cb_valid,
    input  logic [ORC_W-1:0]  cb_orc,
    input  logic              cb_eob,
    input  logic [DATA_W-1:0] cr_data,
    input  logic              cr_valid,
    input  logic [ORC_W-1:0]  cr_orc,
    input  logic              cr_eob,
    output logic [DATA_W-1:0] out_data,
    output logic [ORC_W-1:0]  out_orc,
    output logic [1:0]        out_chan,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf_err,
    output logic              busy,
    output logic [15:0]       mcu_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    // Entry layout: {data, orc, last, nodata}
    localparam int unsigned EW = DATA_W + ORC_W + 2;

    typedef enum logic [1:0] {StY = 2'd0, StCb = 2'd1, StCr = 2'd2} state_e;

    state_e        state_q;
    logic [EW-1:0] mem_q    [3][DEPTH];
    logic [AW-1:0] wr_ptr_q [3];
    logic [AW-1:0] rd_ptr_q [3];
    logic [AW:0]   cnt_q    [3];

    logic [EW-1:0] push_entry [3];
    logic [EW-1:0] head       [3];
    logic [2:0]    push_req, push_ok, pop, full, empty;

    logic          accept, adv_last, load_en, pop_src, src_marker, marker_pop;
    state_e        src;
    logic [EW-1:0] src_head;

    function automatic state_e next_chan(input state_e s);
        case (s)
            StY:     return StCb;
            StCb:    return StCr;
            default: return StY;
        endcase
    endfunction

    // An eob without a valid word becomes a zero-data marker entry
    assign push_req      = {cr_valid | cr_eob, cb_valid | cb_eob, y_valid | y_eob};
    assign push_entry[0] = y_valid  ? {y_data, y_orc, y_eob, 1'b0}
                                    : {{DATA_W{1'b0}}, {ORC_W{1'b0}}, 2'b11};
    assign push_entry[1] = cb_valid ? {cb_data, cb_orc, cb_eob, 1'b0}
                                    : {{DATA_W{1'b0}}, {ORC_W{1'b0}}, 2'b11};
    assign push_entry[2] = cr_valid ? {cr_data, cr_orc, cr_eob, 1'b0}
                                    : {{DATA_W{1'b0}}, {ORC_W{1'b0}}, 2'b11};

    // FIFO status per channel
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            head[c]  = mem_q[c][rd_ptr_q[c]];
            empty[c] = (cnt_q[c] == '0);
            full[c]  = (cnt_q[c] == (AW+1)'(DEPTH));
        end
    end

    // Pop selection: after an accepted last word the next load already comes from the
    // following channel; a marker found there is deferred one cycle so the state only
    // ever advances by one channel per edge.
    always_comb begin
        accept     = out_valid & out_ready;
        adv_last   = accept & out_last;
        src        = adv_last ? next_chan(state_q) : state_q;
        load_en    = !out_valid | out_ready;
        src_head   = head[src];
        src_marker = src_head[0];
        pop_src    = load_en & !empty[src] & !(adv_last & src_marker);
        marker_pop = pop_src & src_marker;
        pop        = 3'b000;
        pop[src]   = pop_src;
        push_ok    = push_req & (~full | pop);
    end

    // FIFO storage; pointers reset, contents need not
    always_ff @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (push_ok[c]) mem_q[c][wr_ptr_q[c]] <= push_entry[c];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (push_ok[c]) wr_ptr_q[c] <= wr_ptr_q[c] + AW'(1);
                if (pop[c])     rd_ptr_q[c] <= rd_ptr_q[c] + AW'(1);
                if (push_ok[c] && !pop[c])      cnt_q[c] <= cnt_q[c] + (AW+1)'(1);
                else if (!push_ok[c] && pop[c]) cnt_q[c] <= cnt_q[c] - (AW+1)'(1);
            end
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
        end else if (|(push_req & ~push_ok)) begin
            ovf_err <= 1'b1;
        end
    end

    // Channel sequencer with the registered output stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StY;
            out_data  <= '0;
            out_orc   <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (load_en) begin
                out_valid <= pop_src & !src_marker;
                if (pop_src && !src_marker) begin
                    out_data <= src_head[EW-1 -: DATA_W];
                    out_orc  <= src_head[2 +: ORC_W];
                    out_last <= src_head[1];
                    out_chan <= src;
                end
            end
            if (adv_last) begin
                state_q <= src;
            end else if (marker_pop) begin
                state_q <= next_chan(state_q);
            end
        end
    end

`ifdef JSA_MCU_COUNT_EN
    logic mcu_inc;
    assign mcu_inc = (state_q == StCr) & (adv_last | marker_pop);

    // Completed-MCU counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcu_count <= '0;
        end else if (mcu_inc) begin
            mcu_count <= mcu_count + 16'd1;
        end
    end
`else
    assign mcu_count = 16'h0000;
`endif

    assign busy = out_valid | (|(~empty));

endmodule
